// File: rtl/adder_share_arbiter_pkg.sv
// adder_share_arbiter_pkg: FSM encoding and default sizes for the shared-adder arbiter
package adder_share_arbiter_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_ID_W = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/adder_share_arbiter_rr_arbiter_comb.sv
// rr_arbiter_comb: combinational round-robin pick starting at ptr_i
module rr_arbiter_comb #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  // scanning downward lets the offset nearest the pointer win last
  always_comb begin
    j = '0;
    idx_o = '0;
    any_o = |valid_i;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      idx_o = valid_i[j] ? j : idx_o;
    end
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external adder among NUM_REQ requesters
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W = DEF_ID_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       io_req_valid,
  output logic [NUM_REQ-1:0]       io_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] io_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] io_req_b,
  output logic                     io_resp_valid,
  input  logic                     io_resp_ready,
  output logic [ID_W-1:0]          io_resp_id,
  output logic [WIDTH-1:0]         io_resp_sum,
  output logic [WIDTH-1:0]         io_adder_a,
  output logic [WIDTH-1:0]         io_adder_b,
  input  logic [WIDTH-1:0]         io_adder_sum,
  output logic                     io_busy,
  output logic [15:0]              io_done_count
);
  state_e state_q;
  logic [ID_W-1:0] rr_q, rr_d, id_q, gidx;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [15:0] cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic any;
  rr_arbiter_comb #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .valid_i(io_req_valid),
    .ptr_i  (rr_q),
    .grant_o(grant),
    .idx_o  (gidx),
    .any_o  (any)
  );
  assign rr_d = ID_W'((int'(gidx) + 1) % NUM_REQ);
  // ready is gated by reset so nothing looks accepted while reset is held
  assign io_req_ready = (state_q == IDLE && reset) ? grant : '0;
  assign io_resp_valid = state_q == RESP;
  assign io_resp_id = id_q;
  assign io_resp_sum = sum_q;
  assign io_adder_a = a_q;
  assign io_adder_b = b_q;
  assign io_busy = state_q != IDLE;
  assign io_done_count = cnt_q;
  always_ff @(posedge clock)
    if (!reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else
      case (state_q)
        IDLE: if (any) begin
          state_q <= CALC;
          a_q <= io_req_a[int'(gidx)*WIDTH +: WIDTH];
          b_q <= io_req_b[int'(gidx)*WIDTH +: WIDTH];
          id_q <= gidx;
          rr_q <= rr_d;
        end
        CALC: begin
          sum_q <= io_adder_sum;
          state_q <= RESP;
        end
        RESP: if (io_resp_ready) begin
          cnt_q <= cnt_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed pins plus randomized traffic against a transaction-level model
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clock = 0, reset = 0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic resp_valid, resp_ready;
  logic [1:0] resp_id;
  logic [W-1:0] resp_sum, adder_a, adder_b, adder_sum;
  logic busy;
  logic [15:0] done_count;
  int total = 0, bad = 0;
  adder_share_arbiter dut (
    .clock(clock), .reset(reset),
    .io_req_valid(req_valid), .io_req_ready(req_ready),
    .io_req_a(req_a), .io_req_b(req_b),
    .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
    .io_resp_id(resp_id), .io_resp_sum(resp_sum),
    .io_adder_a(adder_a), .io_adder_b(adder_b), .io_adder_sum(adder_sum),
    .io_busy(busy), .io_done_count(done_count)
  );
  assign adder_sum = adder_a + adder_b;
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // transaction-level model: one outstanding request, response one cycle after the compute cycle
  bit m_busy = 0;
  int m_age = 0, m_ptr = 0, m_id = 0, m_glast = -1;
  logic [W-1:0] m_a = 0, m_b = 0, m_sum = 0, m_pend = 0;
  logic [15:0] m_cnt = 0;
  always @(posedge clock) begin
    int g;
    m_glast = -1;
    g = pick(req_valid, m_ptr);
    if (!reset) begin
      m_busy = 0; m_ptr = 0; m_cnt = 0; m_a = 0; m_b = 0; m_sum = 0; m_id = 0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_glast = g; m_busy = 1; m_age = 0; m_id = g;
        m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W];
        m_pend = m_a + m_b;
        m_ptr = (g + 1) % N;
      end
    end else if (m_age == 0) begin
      m_age = 1; m_sum = m_pend;
    end else if (resp_ready) begin
      m_busy = 0; m_cnt++;
    end
  end
  always @(negedge clock) begin
    int g;
    logic [N-1:0] er;
    g = pick(req_valid, m_ptr);
    er = (reset && !m_busy && g >= 0) ? N'(1) << g : '0;
    chk("ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_age == 1));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done_count", 32'(done_count), 32'(m_cnt));
    chk("adder_a", adder_a, m_a);
    chk("adder_b", adder_b, m_b);
    chk("resp_id", 32'(resp_id), 32'(m_id));
    chk("resp_sum", resp_sum, m_sum);
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic txn(input int i, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic [31:0] sum, output int id);
    int n;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1;
    n = 0;
    @(negedge clock);
    while (!req_ready[i] && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("grant_wait", 32'(n < 20), 32'd1);
    @(posedge clock);
    #1 req_valid[i] = 0;
    lat = 1;
    @(negedge clock);
    while (!resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    sum = resp_sum;
    id = resp_id;
  endtask
  int lat, id, got, cyc;
  int ids[5], ts[5];
  logic [31:0] sum;
  initial begin
    reset = 0;
    resp_ready = 1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(i);
      req_b[i*W +: W] = 32'd1;
    end
    repeat (3) tick;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(done_count), 0);
    chk("rst_adder_a", adder_a, 0);
    tick;
    reset = 1;
    @(negedge clock);
    chk("first_grant", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    reset = 0;
    @(negedge clock);
    chk("calc_busy", 32'(busy), 1);
    tick;
    reset = 1;
    @(negedge clock);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(resp_valid), 0);
    chk("midrst_count", 32'(done_count), 0);
    req_valid = '1;
    #1 chk("midrst_ptr", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick;
    txn(1, 32'd5, 32'd7, lat, sum, id);
    chk("single_lat", 32'(lat), 2);
    chk("single_sum", sum, 32'd12);
    chk("single_id", 32'(id), 1);
    @(negedge clock);
    chk("single_count", 32'(done_count), 1);
    tick;
    txn(0, 32'hFFFF_FFFF, 32'h2, lat, sum, id);
    chk("wrap_sum", sum, 32'h1);
    chk("wrap_id", 32'(id), 0);
    tick;
    reset = 0;
    tick;
    reset = 1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(100 + i);
      req_b[i*W +: W] = 32'(i);
    end
    req_valid = '1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (resp_valid) begin
        ids[got] = resp_id;
        ts[got] = cyc;
        got++;
      end
    end
    req_valid = '0;
    chk("rr_count", 32'(got), 5);
    for (int k = 0; k < 5; k++) chk("rr_id", 32'(ids[k]), 32'(k % 4));
    for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(ts[k] - ts[k-1]), 3);
    tick;
    resp_ready = 0;
    txn(2, 32'h1234, 32'h1111, lat, sum, id);
    req_valid = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_sum", resp_sum, 32'h2345);
      chk("bp_id", 32'(resp_id), 2);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    resp_ready = 1;
    @(negedge clock);
    chk("bp_release", 32'(busy), 0);
    req_valid = '0;
    tick;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_glast == i || !req_valid[i]) begin
          req_valid[i] = ($urandom % 3) == 0;
          req_a[i*W +: W] = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
          req_b[i*W +: W] = $urandom;
        end else if ($urandom % 8 == 0) req_valid[i] = 0;
      end
      resp_ready = ($urandom % 4) != 0;
      reset = ($urandom % 150) != 0;
      tick;
    end
    reset = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one external combinational 32-bit adder instance among NUM_REQ requesters.
- Accepts add requests with a valid/ready handshake, arbitrates them round-robin, and sequences operands into the shared adder.
- Registers the sum and returns it with the requester ID over a single response valid/ready channel.
- Sits between requester logic and the adder black-box wrapper in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and sum width.
- ID_W, 2, requester-ID width; equals clog2(NUM_REQ).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset asserted.
- io_req_valid  in  NUM_REQ  per-requester request valid.
- io_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- io_req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- io_req_b  in  NUM_REQ*WIDTH  packed operand B, same packing as io_req_a.
- io_resp_valid  out  1  response valid.
- io_resp_ready  in  1  response consumer ready.
- io_resp_id  out  ID_W  index of the requester that owns the response.
- io_resp_sum  out  WIDTH  registered sum.
- io_adder_a  out  WIDTH  operand A to the shared adder.
- io_adder_b  out  WIDTH  operand B to the shared adder.
- io_adder_sum  in  WIDTH  sum from the shared adder; combinational in the same cycle.
- io_busy  out  1  high whenever state is not IDLE.
- io_done_count  out  16  count of completed responses; wraps 0xFFFF -> 0.

Behaviour:
- Reset (reset==0 at a clock edge) sets:
  - state=IDLE, rr_ptr=0.
  - Operand registers, id register and sum register to 0.
  - done_count=0.
  - All outputs therefore 0: io_req_ready=0, io_resp_valid=0, io_adder_a/b=0, io_busy=0.
- Reset asserted mid-transaction drops that transaction silently; no response is issued.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = first i with io_req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - io_req_ready[grant]=1 combinationally in that cycle; all other ready bits are 0.
  - On a handshake: latch a, b and id=grant; rr_ptr <= (grant+1) mod NUM_REQ; go to CALC.
  - If no valid is set: stay in IDLE; rr_ptr unchanged.
- CALC:
  - io_adder_a/b driven from the operand registers.
  - sum_reg <= io_adder_sum at the end of the cycle; go to RESP.
  - io_req_ready=0.
- RESP:
  - io_resp_valid=1; io_resp_sum=sum_reg; io_resp_id=id_reg; all three stable until the handshake.
  - On io_resp_ready=1: done_count++ and go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- Adder operand outputs always reflect the operand registers, so they hold their last values outside CALC.
- Arithmetic: sum is modulo 2^WIDTH; carry-out is discarded (0xFFFFFFFF+1=0).
- Latency, request handshake to resp_valid: 2 cycles.
- Maximum throughput: one transaction every 3 cycles. No acceptance in RESP, even when io_resp_ready is high in that cycle.
- Requesters must hold valid and operands stable until ready. A requester deasserting valid before grant is legal; it is simply not granted.
- A requester may hold valid high continuously; round-robin guarantees every other valid requester is granted within NUM_REQ transactions.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, CALC=2'd1, RESP=2'd2.
  - Default constants NUM_REQ, WIDTH, ID_W.
- One sub-module: rr_arbiter_comb.
  - Inputs: valid vector, rr_ptr. Outputs: one-hot grant, grant index, any_valid.
  - Purely combinational; rr_ptr update stays in the parent.
- The adder itself stays external, instantiated by the enclosing wrapper and connected through the io_adder_* ports.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all valids=1 -> all outputs 0, io_busy=0, io_done_count=0; release -> requester 0 granted on the first cycle.
- Single request: req1 a=5, b=7, resp_ready=1 -> io_resp_valid rises 2 cycles after the handshake; sum=12, id=1, done_count=1.
- Wrap-around: req0 a=0xFFFFFFFF, b=0x00000002 -> sum=0x00000001.
- Round-robin fairness: all 4 valids held high, resp_ready=1 -> grant order 0,1,2,3,0; each response 3 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/sum/id stable; all io_req_ready=0; io_busy=1; completes when ready rises.
- Mid-operation reset: reset=0 during CALC -> next cycle state IDLE, no response, rr_ptr=0, done_count=0.
